fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that funnels NUM_REQ word-sized write
// requests into a single FIFO write port, with bounded retry on a
// rejected write.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   req, req_data       per-requester level request and word (requester i
//                       at req_data[i*FIFO_WIDTH +: FIFO_WIDTH])
//   done, err           registered one-cycle pulses for the requester whose
//                       word was accepted / dropped after MAX_RETRY retries
//   wr_en, data_in      FIFO write port (wr_en high only in WRITE)
//   full                FIFO full flag, blocks grants and reissues
//   wr_ack, overflow    FIFO registered write response, valid the cycle
//                       after wr_en
//   accept_cnt          saturating count of accepted writes
module fifo_wr_arb #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_RETRY  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [15:0]                   accept_cnt
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW  = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, WRITE, ACK, RETRY} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          cur_id_q, cur_id_d;
    logic [FIFO_WIDTH-1:0]   cur_data_q, cur_data_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [IDW-1:0]          last_grant_q, last_grant_d;
    logic [15:0]             accept_cnt_q, accept_cnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [NUM_REQ-1:0]      err_q, err_d;

    logic [FIFO_WIDTH-1:0]   req_words [NUM_REQ];
    logic                    found;
    logic [IDW-1:0]          win_id;
    logic [IDW-1:0]          cand;

    // Any wr_ack==0 response counts as a failed write, so overflow carries
    // no extra information here.
    logic                    unused_overflow;
    assign unused_overflow = overflow;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_words[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // Round-robin search from last_grant+1; the last candidate visited is
    // last_grant itself, so a just-finished requester only wins again when
    // nobody else is asking.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        cur_data_d   = cur_data_q;
        retry_d      = retry_q;
        last_grant_d = last_grant_q;
        accept_cnt_d = accept_cnt_q;
        done_d       = '0;
        err_d        = '0;
        case (state_q)
            IDLE: begin
                if (found && !full) begin
                    cur_id_d   = win_id;
                    cur_data_d = req_words[win_id];
                    retry_d    = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: state_d = ACK;
            ACK: begin
                if (wr_ack) begin
                    done_d       = NUM_REQ'(1) << cur_id_q;
                    last_grant_d = cur_id_q;
                    if (accept_cnt_q != 16'hFFFF) accept_cnt_d = accept_cnt_q + 16'd1;
                    state_d      = IDLE;
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    err_d        = NUM_REQ'(1) << cur_id_q;
                    last_grant_d = cur_id_q;
                    state_d      = IDLE;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = RETRY;
                end
            end
            RETRY: begin
                if (!full) state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_id_q     <= '0;
            cur_data_q   <= '0;
            retry_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            accept_cnt_q <= '0;
            done_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cur_id_q     <= cur_id_d;
            cur_data_q   <= cur_data_d;
            retry_q      <= retry_d;
            last_grant_q <= last_grant_d;
            accept_cnt_q <= accept_cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign wr_en      = (state_q == WRITE);
    assign data_in    = cur_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: a registered FIFO response model plus a scoreboard
// of expected done/err pulses (requester vector and cycle) that a negedge
// monitor pops and compares.
module tb_fifo_wr_arb;
    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   done, err;
    logic           wr_en;
    logic [W-1:0]   data_in;
    logic           full = 1'b0;
    logic           wr_ack = 1'b0;
    logic           overflow = 1'b0;
    logic [15:0]    accept_cnt;
    logic           fail_mode = 1'b0;

    fifo_wr_arb #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .done(done), .err(err), .wr_en(wr_en), .data_in(data_in),
        .full(full), .wr_ack(wr_ack), .overflow(overflow),
        .accept_cnt(accept_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO: registered response the cycle after wr_en.
    always @(posedge clk) begin
        wr_ack   <= wr_en & ~fail_mode;
        overflow <= wr_en & fail_mode;
    end

    typedef struct {
        logic         is_err;
        logic [N-1:0] vec;
        int           at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [N-1:0] mon_d, mon_r;

    int n_chk  = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        if (|done || |err) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: done=%b err=%b at cycle %0d, expected none", done, err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_d = mon_e.is_err ? '0 : mon_e.vec;
                mon_r = mon_e.is_err ? mon_e.vec : '0;
                if (done !== mon_d || err !== mon_r || cyc != mon_e.at) begin
                    n_fail++;
                    $display("FAIL pulse: done=%b err=%b cycle=%0d, expected done=%b err=%b cycle=%0d",
                             done, err, cyc, mon_d, mon_r, mon_e.at);
                end
            end
        end
    end

    task automatic push(input logic is_err, input logic [N-1:0] vec, input int at);
        exp_t e;
        e.is_err = is_err; e.vec = vec; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; req_data = '0; full = 1'b0; fail_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk += 5;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== '0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        if (data_in !== '0) begin n_fail++; $display("FAIL reset_data_in: got %h want 0", data_in); end
        if (accept_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", accept_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int t;
        do_reset();
        req_data[15:0] = 16'hA5A5; req = 4'b0001; t = cyc;
        push(1'b0, 4'b0001, t + 3);
        @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b1 || data_in !== 16'hA5A5) begin
            n_fail++; $display("FAIL single_write: wr_en=%b data=%h want 1/a5a5", wr_en, data_in);
        end
        @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL single_ack_wr_en: got %b want 0", wr_en); end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        n_chk++;
        if (accept_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", accept_cnt); end
    endtask

    task automatic test_contention();
        int t;
        logic [W-1:0] wd [N];
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        do_reset();
        req_data = {wd[3], wd[2], wd[1], wd[0]}; req = 4'b1111; t = cyc;
        for (int k = 0; k < 5; k++) push(1'b0, 4'b0001 << (k % N), t + 3 + 3*k);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (wr_en !== 1'b1 || data_in !== wd[k % N]) begin
                n_fail++; $display("FAIL contention_write%0d: wr_en=%b data=%h want 1/%h", k, wr_en, data_in, wd[k % N]);
            end
            repeat (2) @(negedge clk);
        end
        req = '0;
        @(negedge clk);
        n_chk++;
        if (accept_cnt !== 16'd5) begin n_fail++; $display("FAIL contention_cnt: got %0d want 5", accept_cnt); end
    endtask

    task automatic test_full_stall();
        int t;
        int bad;
        do_reset();
        full = 1'b1; req_data[31:16] = 16'hBEEF; req = 4'b0010; t = cyc; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_no_write: %0d wr_en cycles while full, want 0", bad); end
        full = 1'b0;
        push(1'b0, 4'b0010, t + 13);
        @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b1 || data_in !== 16'hBEEF) begin
            n_fail++; $display("FAIL stall_release: wr_en=%b data=%h want 1/beef", wr_en, data_in);
        end
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_retry();
        int t;
        int pulses;
        do_reset();
        fail_mode = 1'b1; req_data[15:0] = 16'hDEAD; req = 4'b0001; t = cyc; pulses = 0;
        push(1'b1, 4'b0001, t + 12);
        repeat (12) begin
            @(negedge clk);
            if (wr_en === 1'b1) pulses++;
        end
        req = '0;
        repeat (3) begin
            @(negedge clk);
            if (wr_en === 1'b1) pulses++;
        end
        n_chk += 2;
        if (pulses != 4) begin n_fail++; $display("FAIL retry_pulses: got %0d wr_en pulses want 4", pulses); end
        if (accept_cnt !== 16'd0) begin n_fail++; $display("FAIL retry_cnt: got %0d want 0", accept_cnt); end
        fail_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        req_data[47:32] = 16'h7777; req = 4'b0100;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk += 3;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
        if (done !== '0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        if (err !== '0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err); end
        rst_n = 1'b1;
        req_data = {16'h3B3B, 16'h0000, 16'h0000, 16'h0A0A}; req = 4'b1001; t = cyc;
        push(1'b0, 4'b0001, t + 3);
        push(1'b0, 4'b1000, t + 6);
        @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b1 || data_in !== 16'h0A0A) begin
            n_fail++; $display("FAIL midrst_first: wr_en=%b data=%h want 1/0a0a", wr_en, data_in);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (wr_en !== 1'b1 || data_in !== 16'h3B3B) begin
            n_fail++; $display("FAIL midrst_second: wr_en=%b data=%h want 1/3b3b", wr_en, data_in);
        end
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int t;
        do_reset();
        // Stand-in for 65534 prior accepted writes.
        force dut.accept_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.accept_cnt_q;
        req_data[15:0] = 16'h5A5A; req = 4'b0001; t = cyc;
        push(1'b0, 4'b0001, t + 3);
        push(1'b0, 4'b0001, t + 6);
        repeat (4) @(negedge clk);
        n_chk++;
        if (accept_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", accept_cnt); end
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
        n_chk++;
        if (accept_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", accept_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_retry();
        test_reset_mid();
        test_saturation();
        repeat (3) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL missing_pulses: %0d expected pulses never seen, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
